// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: FSM state type and width helpers shared by the clock period monitor
package clk_mon_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, STUCK} state_t;
  function automatic logic [63:0] all_ones(input int w);
    return ~(64'hFFFF_FFFF_FFFF_FFFF << w);
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchronizer with single-cycle rise/fall pulses
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);
  logic r_s1, r_s2, r_s3;
  // r_s1/r_s2 synchronize d; r_s3 holds the previous synchronized level for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) {r_s3, r_s2, r_s1} <= 3'b000;
    else {r_s3, r_s2, r_s1} <= {r_s2, r_s1, d};
  end
  assign level = r_s2;
  assign rise  = r_s2 & ~r_s3;
  assign fall  = ~r_s2 & r_s3;
endmodule

// File: rtl/clk_period_monitor.sv
// clk_period_monitor: measures sig_in rise-to-rise period in clk cycles, tracks min/max, edges and stall
module clk_period_monitor
  import clk_mon_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] period_min,
  output logic [CNT_W-1:0] period_max,
  output logic [31:0]      edge_count,
  output logic             stuck,
  output logic             stuck_level
);
  localparam logic [CNT_W-1:0] P_ONES = CNT_W'(all_ones(CNT_W));
  localparam logic [CNT_W-1:0] P_TO   = CNT_W'(TIMEOUT);

  logic             w_level, w_rise, w_fall, w_edge, w_meas, w_enter;
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, r_idle, w_idle_nxt;
  logic [CNT_W-1:0] r_period, r_min, r_max;
  logic [31:0]      r_edges;
  logic             r_valid, r_lvl;

  sync_edge_detect u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sig_in),
    .level(w_level),
    .rise (w_rise),
    .fall (w_fall)
  );

  assign w_edge = w_rise | w_fall;

  // next-state, counter updates and measurement strobes; a rise always re-arms the period counter
  always_comb begin
    w_idle_nxt  = w_edge ? '0 : (r_idle == P_TO) ? r_idle : r_idle + CNT_W'(1);
    w_cnt_nxt   = w_rise ? CNT_W'(1) : (r_state == MEASURE && r_cnt != P_ONES) ? r_cnt + CNT_W'(1) : r_cnt;
    w_state_nxt = w_rise ? MEASURE :
                  (w_fall && r_state == STUCK) ? IDLE :
                  (r_state != STUCK && w_idle_nxt == P_TO) ? STUCK : r_state;
    w_meas      = w_rise && r_state == MEASURE;
    w_enter     = r_state != STUCK && w_state_nxt == STUCK;
  end

  // state, counters and statistics; clr behaves like reset except for the synchronizer
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idle   <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_min    <= P_ONES;
      r_max    <= '0;
      r_edges  <= '0;
      r_lvl    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idle  <= w_idle_nxt;
      r_valid <= w_meas;
      if (w_meas) begin
        r_period <= r_cnt;
        r_min    <= (r_cnt < r_min) ? r_cnt : r_min;
        r_max    <= (r_cnt > r_max) ? r_cnt : r_max;
      end
      if (w_rise) r_edges <= r_edges + 32'd1;
      if (w_enter) r_lvl <= w_level;
    end
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign period_min   = r_min;
  assign period_max   = r_max;
  assign edge_count   = r_edges;
  assign stuck        = r_state == STUCK;
  assign stuck_level  = r_lvl;
endmodule

// File: tb/tb_clk_period_monitor.sv
// tb_clk_period_monitor: directed stimulus with an event-level reference model checked every cycle
module tb_clk_period_monitor;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1024;

  logic clk = 1'b0, rst_n = 1'b0, sig_in = 1'b0, clr = 1'b0;
  logic [CNT_W-1:0] period, period_min, period_max;
  logic [31:0] edge_count;
  logic period_valid, stuck, stuck_level;

  int n_chk = 0, n_fail = 0, n_vld = 0, cyc = 0;

  clk_period_monitor #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clr(clr),
    .period(period), .period_valid(period_valid), .period_min(period_min),
    .period_max(period_max), .edge_count(edge_count), .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pp(input int hi, input int lo);
    sig_in = 1'b1;
    tick(hi);
    sig_in = 1'b0;
    tick(lo);
  endtask

  // sig_in as the design sees it: two samples of synchronizer delay, cleared by reset
  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) {h2, h1, h0} <= 3'b000;
    else {h2, h1, h0} <= {h1, h0, sig_in};
  end

  // reference model: periods are differences between rise cycles; stuck is time since last edge
  logic        m_live = 1'b0, m_armed = 1'b0, m_valid = 1'b0, m_lvl = 1'b0, m_stk_prev = 1'b0;
  logic [15:0] m_period = '0, m_min = '1, m_max = '0;
  logic [31:0] m_edges = '0;
  int          m_ref = 0, m_last = 0;
  always @(negedge clk) begin
    logic stk, r, f;
    int   p;
    if (m_live) begin
      stk = (cyc - m_ref) >= TIMEOUT + 1;
      if (stk && !m_stk_prev) m_lvl = h1;
      m_stk_prev = stk;
      if (stk) m_armed = 1'b0;
      chk("period", 32'(period), 32'(m_period));
      chk("period_valid", 32'(period_valid), 32'(m_valid));
      chk("period_min", 32'(period_min), 32'(m_min));
      chk("period_max", 32'(period_max), 32'(m_max));
      chk("edge_count", edge_count, m_edges);
      chk("stuck", 32'(stuck), 32'(stk));
      chk("stuck_level", 32'(stuck_level), 32'(m_lvl));
      if (period_valid === 1'b1) n_vld++;
    end
    if (!rst_n || clr) begin
      m_live = 1'b1; m_armed = 1'b0; m_valid = 1'b0; m_lvl = 1'b0; m_stk_prev = 1'b0;
      m_period = '0; m_min = '1; m_max = '0; m_edges = '0; m_ref = cyc;
    end else if (m_live) begin
      m_valid = 1'b0;
      r = h1 & ~h2;
      f = ~h1 & h2;
      if (r || f) m_ref = cyc;
      if (r) begin
        m_edges++;
        if (m_armed) begin
          p = cyc - m_last;
          m_period = 16'(p);
          m_valid = 1'b1;
          if (16'(p) < m_min) m_min = 16'(p);
          if (16'(p) > m_max) m_max = 16'(p);
        end
        m_armed = 1'b1;
        m_last = cyc;
      end
    end
  end

  initial begin
    tick(3);
    rst_n = 1'b1;
    chk("rst period", 32'(period), 0);
    chk("rst valid", 32'(period_valid), 0);
    chk("rst min", 32'(period_min), 32'h0000_FFFF);
    chk("rst max", 32'(period_max), 0);
    chk("rst edges", edge_count, 0);
    chk("rst stuck", 32'(stuck), 0);
    // basic square wave, 5 high / 5 low
    for (int i = 0; i < 4; i++) pp(5, 5);
    chk("basic period", 32'(period), 10);
    chk("basic min", 32'(period_min), 10);
    chk("basic max", 32'(period_max), 10);
    chk("basic edges", edge_count, 4);
    // min/max tracking over periods 10, 20, 6, then hold high until stuck
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    pp(5, 5);
    pp(10, 10);
    pp(3, 3);
    sig_in = 1'b1;
    tick(TIMEOUT + 2);
    chk("mm period", 32'(period), 6);
    chk("mm min", 32'(period_min), 6);
    chk("mm max", 32'(period_max), 20);
    chk("mm edges", edge_count, 4);
    chk("stuck hi early", 32'(stuck), 0);
    tick(1);
    chk("stuck hi", 32'(stuck), 1);
    chk("stuck hi level", 32'(stuck_level), 1);
    sig_in = 1'b0;
    tick(2);
    chk("stuck before fall", 32'(stuck), 1);
    tick(1);
    chk("stuck cleared", 32'(stuck), 0);
    n_vld = 0;
    sig_in = 1'b1;
    tick(6);
    chk("post-stuck no valid", 32'(n_vld), 0);
    chk("post-stuck edges", edge_count, 5);
    sig_in = 1'b0;
    tick(4);
    sig_in = 1'b1;
    tick(6);
    chk("post-stuck period", 32'(period), 10);
    chk("post-stuck valids", 32'(n_vld), 1);
    // never toggles after reset
    sig_in = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(TIMEOUT - 1);
    chk("idle stuck early", 32'(stuck), 0);
    tick(1);
    chk("idle stuck", 32'(stuck), 1);
    chk("idle stuck level", 32'(stuck_level), 0);
    chk("idle min", 32'(period_min), 32'h0000_FFFF);
    chk("idle max", 32'(period_max), 0);
    // clr coincident with a rise during MEASURE
    pp(5, 5);
    pp(5, 5);
    chk("pre-clr period", 32'(period), 10);
    sig_in = 1'b1;
    tick(2);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("clr period", 32'(period), 0);
    chk("clr valid", 32'(period_valid), 0);
    chk("clr min", 32'(period_min), 32'h0000_FFFF);
    chk("clr max", 32'(period_max), 0);
    chk("clr edges", edge_count, 0);
    tick(4);
    sig_in = 1'b0;
    tick(5);
    pp(7, 7);
    sig_in = 1'b1;
    tick(5);
    chk("after clr period", 32'(period), 14);
    chk("after clr min", 32'(period_min), 14);
    chk("after clr edges", edge_count, 2);
    // reset between rises
    sig_in = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    n_vld = 0;
    chk("mid rst period", 32'(period), 0);
    chk("mid rst max", 32'(period_max), 0);
    chk("mid rst edges", edge_count, 0);
    pp(4, 4);
    sig_in = 1'b1;
    tick(4);
    chk("mid rst valids", 32'(n_vld), 1);
    chk("mid rst new period", 32'(period), 8);
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
